// File: rtl/spike_event_logger.sv
// Timestamps rising edges of a spike line and queues {wrap, ts} events in a small FIFO.
// Events that arrive while the FIFO is full are counted in a saturating drop counter.
module spike_event_logger #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     spike_in,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [TS_W-1:0]          evt_ts,
  output logic                     evt_wrap,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic            wrap;
    logic [TS_W-1:0] ts;
  } evt_t;

  evt_t            mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            spike_prev_q;
  logic            wrap_pend_q, wrap_pend_d;
  logic [7:0]      drop_q, drop_d;

  logic full, pop, det, push, drop, ts_wrap;
  evt_t head;

  assign evt_valid = (cnt_q != '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign pop       = evt_valid & evt_ready;
  assign det       = enable & spike_in & ~spike_prev_q;
  // A full FIFO still accepts the event when the head leaves on the same edge.
  assign push      = det & (~full | pop);
  assign drop      = det & ~push;
  assign ts_wrap   = enable & (&ts_q);

  always_comb begin
    ts_d        = ts_q;
    wrap_pend_d = wrap_pend_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    if (enable) ts_d = ts_q + TS_W'(1);
    // A wrap on the write edge belongs to the next event, so it wins over the clear.
    if (ts_wrap)   wrap_pend_d = 1'b1;
    else if (push) wrap_pend_d = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts_q         <= '0;
      spike_prev_q <= 1'b0;
      wrap_pend_q  <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      drop_q       <= '0;
    end else begin
      ts_q         <= ts_d;
      spike_prev_q <= spike_in;
      wrap_pend_q  <= wrap_pend_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) mem_q[wr_ptr_q] <= '{wrap: wrap_pend_q, ts: ts_q};
  end

  assign head       = mem_q[rd_ptr_q];
  assign evt_ts     = evt_valid ? head.ts : '0;
  assign evt_wrap   = evt_valid ? head.wrap : 1'b0;
  assign fifo_count = cnt_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_spike_event_logger.sv
// Random and directed stimulus for spike_event_logger; a queue scoreboard holds expected
// events and a negedge monitor compares the presented head and counters against the model.
module tb_spike_event_logger;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       spike_in = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_ts;
  logic       evt_wrap;
  logic [2:0] fifo_count;
  logic [7:0] drop_cnt;

  spike_event_logger #(.TS_W(8), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .spike_in(spike_in),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_ts(evt_ts),
    .evt_wrap(evt_wrap), .fifo_count(fifo_count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: events are {wrap, ts}.
  logic [8:0] exp_q[$];
  int m_ts = 0, m_cnt = 0, m_drop = 0;
  bit m_prev = 0, m_wp = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, wait for the edge, advance the model, settle 1 time unit past the edge.
  task automatic tick(input bit rn, input bit en, input bit sp, input bit rdy);
    bit pop, det, push;
    reset_n = rn; enable = en; spike_in = sp; evt_ready = rdy;
    @(posedge clk);
    if (!rn) begin
      m_ts = 0; m_cnt = 0; m_drop = 0; m_prev = 0; m_wp = 0;
      exp_q.delete();
    end else begin
      pop  = (m_cnt > 0) && rdy;
      det  = en && sp && !m_prev;
      push = det && (m_cnt < 4 || pop);
      if (push) exp_q.push_back({m_wp, 8'(m_ts)});
      if (det && !push && m_drop < 255) m_drop++;
      if (en && m_ts == 255) m_wp = 1;
      else if (push) m_wp = 0;
      m_cnt = m_cnt + int'(push) - int'(pop);
      if (en) m_ts = (m_ts + 1) % 256;
      m_prev = sp;
    end
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (!evt_valid) break;
      tick(1, 1, 0, 1);
    end
    chk("drain_empty", int'(evt_valid), 0);
  endtask

  // Monitor: outputs reflect the last edge, inputs are those for the next edge.
  always @(negedge clk) begin
    chk("valid_vs_model", int'(evt_valid), int'(exp_q.size() != 0));
    chk("count_vs_model", int'(fifo_count), m_cnt);
    chk("drop_vs_model", int'(drop_cnt), m_drop);
    if (evt_valid) begin
      if (exp_q.size() != 0) begin
        chk("head_evt", int'({evt_wrap, evt_ts}), int'(exp_q[0]));
        if (evt_ready && reset_n) void'(exp_q.pop_front());
      end
    end else begin
      chk("idle_zero", int'({evt_wrap, evt_ts}), 0);
    end
  end

  bit sp_r;

  initial begin
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_count", int'(fifo_count), 0);

    // First event at ts=5
    repeat (5) tick(1, 1, 0, 0);
    tick(1, 1, 1, 0);
    chk("ts5_valid", int'(evt_valid), 1);
    chk("ts5_ts", int'(evt_ts), 5);
    chk("ts5_wrap", int'(evt_wrap), 0);
    chk("ts5_count", int'(fifo_count), 1);
    tick(1, 1, 0, 0);
    drain();

    // Sustained spike -> one event
    repeat (10) tick(1, 1, 1, 0);
    tick(1, 1, 0, 0);
    chk("sustain_count", int'(fifo_count), 1);
    drain();

    // Overflow: 6 spikes, 4 stored, 2 dropped
    tick(0, 0, 0, 0);
    repeat (6) begin tick(1, 1, 1, 0); tick(1, 1, 0, 0); end
    chk("ovf_count", int'(fifo_count), 4);
    chk("ovf_drop", int'(drop_cnt), 2);
    chk("ovf_head", int'(evt_ts), 0);

    // Full FIFO with simultaneous pop and push at ts=12
    tick(1, 1, 1, 1);
    chk("fullpp_count", int'(fifo_count), 4);
    chk("fullpp_drop", int'(drop_cnt), 2);
    repeat (3) tick(1, 1, 0, 1);
    chk("fullpp_tail", int'(evt_ts), 12);
    drain();

    // Wrap flag: event at 250, next at 38 after one wrap, then one without
    tick(0, 0, 0, 0);
    repeat (250) tick(1, 1, 0, 0);
    tick(1, 1, 1, 0);
    chk("wrap_e1_ts", int'(evt_ts), 250);
    chk("wrap_e1_wrap", int'(evt_wrap), 0);
    repeat (43) tick(1, 1, 0, 0);
    tick(1, 1, 1, 0);
    chk("wrap_count", int'(fifo_count), 2);
    tick(1, 1, 0, 1);
    chk("wrap_e2_ts", int'(evt_ts), 38);
    chk("wrap_e2_wrap", int'(evt_wrap), 1);
    tick(1, 1, 1, 1);
    chk("wrap_e3_ts", int'(evt_ts), 40);
    chk("wrap_e3_wrap", int'(evt_wrap), 0);
    drain();

    // Drop saturation, then reset clears everything
    tick(0, 0, 0, 0);
    repeat (300) begin tick(1, 1, 1, 0); tick(1, 1, 0, 0); end
    chk("sat_drop", int'(drop_cnt), 255);
    chk("sat_count", int'(fifo_count), 4);
    tick(0, 1, 0, 0);
    chk("rst2_valid", int'(evt_valid), 0);
    chk("rst2_ts", int'(evt_ts), 0);
    chk("rst2_wrap", int'(evt_wrap), 0);
    chk("rst2_count", int'(fifo_count), 0);
    chk("rst2_drop", int'(drop_cnt), 0);

    // Spike held through reset release, then drain with enable low
    tick(0, 1, 1, 0);
    tick(1, 1, 1, 0);
    chk("relspk_count", int'(fifo_count), 1);
    chk("relspk_ts", int'(evt_ts), 0);
    tick(1, 0, 1, 1);
    chk("dis_drain", int'(evt_valid), 0);

    // Randomized traffic
    sp_r = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(2) == 0) sp_r = !sp_r;
      tick(($urandom_range(299) != 0), ($urandom_range(9) != 0), sp_r,
           (i % 512 < 256) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
